retire_trace_v: RTL

//  Retirement trace/performance buffer sitting directly downstream of the 5-stage pipeline top.

---
 rtl/retire_trace_v.sv | 134 +++++++++++++
 1 files changed

// File: rtl/retire_trace_v.sv
// Retirement trace buffer: captures one record per valid retired instruction into a
// show-ahead FIFO and keeps run-time performance counters until HALT retires.
module retire_trace_v #(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned AW         = 4,
   parameter int unsigned CNT_W      = 32,
   parameter logic [31:0] HALT_INSTR = 32'h00000073
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic             wb_isValid,
   input  logic [31:0]      wb_pc,
   input  logic [31:0]      wb_instr,
   input  logic [4:0]       wb_rd,
   input  logic             wb_reg_write,
   input  logic [31:0]      wb_data,
   input  logic             stall_in,
   input  logic             flush_in,
   input  logic             rd_en,
   output logic             rd_valid,
   output logic [31:0]      rd_pc,
   output logic [31:0]      rd_instr,
   output logic [4:0]       rd_rd,
   output logic             rd_we,
   output logic [31:0]      rd_data,
   output logic [AW:0]      level,
   output logic             full,
   output logic             overflow,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] data;
   } rec_t;

   state_t           state_q;
   rec_t             mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      level_q, level_d;
   logic             overflow_q;
   logic [CNT_W-1:0] cycle_q, retire_q, stall_q, flush_q, drop_q;

   logic run, push_req, pop, full_w, push_ok, drop, halt_hit;
   rec_t head;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + CNT_W'(1) : v;
   endfunction

   // A full FIFO still accepts a push when the head is popped in the same cycle.
   always_comb begin
      run      = (state_q == S_RUN);
      push_req = run & wb_isValid;
      halt_hit = push_req & (wb_instr == HALT_INSTR);
      full_w   = (level_q == (AW+1)'(DEPTH));
      pop      = rd_en & (level_q != '0);
      push_ok  = push_req & (~full_w | pop);
      drop     = push_req & full_w & ~pop;
      level_d  = level_q;
      case ({push_ok, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state_q    <= S_IDLE;
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         cycle_q    <= '0;
         retire_q   <= '0;
         stall_q    <= '0;
         flush_q    <= '0;
         drop_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE:  if (enable) state_q <= S_RUN;
            S_RUN: begin
               if (halt_hit)     state_q <= S_HALTED;
               else if (!enable) state_q <= S_IDLE;
            end
            default: state_q <= state_q;
         endcase
         if (push_ok) wptr_q <= wptr_q + 1'b1;
         if (pop)     rptr_q <= rptr_q + 1'b1;
         level_q <= level_d;
         if (drop) overflow_q <= 1'b1;
         cycle_q  <= sat_inc(cycle_q,  run);
         retire_q <= sat_inc(retire_q, push_ok);
         stall_q  <= sat_inc(stall_q,  run & stall_in);
         flush_q  <= sat_inc(flush_q,  run & flush_in);
         drop_q   <= sat_inc(drop_q,   drop);
      end
   end

   // Storage needs no reset: stale entries are masked by rd_valid.
   always_ff @(posedge clk) begin
      if (push_ok && !(reset || clear))
         mem_q[wptr_q] <= '{pc: wb_pc, instr: wb_instr, rd: wb_rd, we: wb_reg_write, data: wb_data};
   end

   always_comb begin
      head     = mem_q[rptr_q];
      rd_valid = (level_q != '0);
      {rd_pc, rd_instr, rd_rd, rd_we, rd_data} = rd_valid ? head : '0;
      level      = level_q;
      full       = full_w;
      overflow   = overflow_q;
      halted     = (state_q == S_HALTED);
      cycle_cnt  = cycle_q;
      retire_cnt = retire_q;
      stall_cnt  = stall_q;
      flush_cnt  = flush_q;
      drop_cnt   = drop_q;
   end

endmodule
